// File: rtl/gpred_pkg.sv
// -----------------------------------------------------------------------------
// gpred_pkg
//
// Purpose:
//    Shared definitions for the global branch predictor:
//    - index-mode encodings (GAg = history only, gshare = PC XOR history)
//    - helper functions that give the reset and saturation values of an
//      n-bit saturating direction counter
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package gpred_pkg;

   // Index-mode selection for the MODE parameter of gshare_predictor.
   typedef enum logic [0:0] {
      GPRED_MODE_GAG    = 1'b0,
      GPRED_MODE_GSHARE = 1'b1
   } gpred_mode_e;

   // Reset value of a w-bit counter: weakly not-taken, i.e. 0111..1 with the
   // MSB clear (01 for w=2, 0 for w=1).
   function automatic int unsigned gpred_ctr_init(input int unsigned w);
      return (32'd1 << (w - 32'd1)) - 32'd1;
   endfunction

   // Saturation ceiling of a w-bit counter (all ones).
   function automatic int unsigned gpred_ctr_max(input int unsigned w);
      if (w >= 32'd32) begin
         return 32'hFFFF_FFFF;
      end
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage : gpred_pkg

// File: rtl/gpred_ctr_table.sv
// -----------------------------------------------------------------------------
// gpred_ctr_table
//
// Purpose:
//    Pattern history table of 2**IDX_W saturating direction counters.
//    One combinational read port and one write (update) port. The read port
//    always returns the value held before the current clock edge, so a read
//    and an update of the same entry in one cycle is read-before-write.
//    All entries are initialised to weakly not-taken by the async reset.
//
// Ports:
//    clk          in   clock
//    reset        in   async active-high reset
//    rd_idx_i     in   [IDX_W]  read index
//    rd_ctr_o     out  [CTR_W]  counter value at rd_idx_i
//    wr_en_i      in   1        apply an outcome to wr_idx_i this cycle
//    wr_idx_i     in   [IDX_W]  entry to update
//    wr_taken_i   in   1        outcome: 1 counts up, 0 counts down
// -----------------------------------------------------------------------------
module gpred_ctr_table
   import gpred_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int CTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [CTR_W-1:0] rd_ctr_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   localparam int DEPTH = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(gpred_ctr_init(CTR_W));
   localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(gpred_ctr_max(CTR_W));

   // Read view of every entry; each entry is owned by its own generate block.
   logic [CTR_W-1:0] ctr_all [DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [CTR_W-1:0] ctr_q;
         logic [CTR_W-1:0] ctr_d;
         logic             hit;

         assign hit = wr_en_i && (wr_idx_i == IDX_W'(gi));

         // Saturating step toward the outcome; holds at the rails.
         always_comb begin
            ctr_d = ctr_q;
            if (hit) begin
               if (wr_taken_i) begin
                  if (ctr_q != CTR_MAX) begin
                     ctr_d = ctr_q + CTR_W'(1);
                  end
               end else begin
                  if (ctr_q != '0) begin
                     ctr_d = ctr_q - CTR_W'(1);
                  end
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ctr_q <= CTR_INIT;
            end else begin
               ctr_q <= ctr_d;
            end
         end

         assign ctr_all[gi] = ctr_q;
      end
   endgenerate

   // Read of the current (pre-edge) state gives read-before-write naturally.
   assign rd_ctr_o = ctr_all[rd_idx_i];

endmodule : gpred_ctr_table

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
//
// Purpose:
//    Parametrised global-history branch direction predictor. Fetch issues a
//    predict request with the branch PC; one cycle later a registered
//    response gives the predicted direction, the table index used and the
//    history checkpoint (GHR before the speculative shift). Execute returns
//    the index/checkpoint with the real outcome on the resolve port; the
//    counter is trained and, on a mispredict, the GHR is rebuilt from the
//    checkpoint plus the real outcome.
//
//    MODE selects the index hash: GAg (history only) or gshare (PC XOR
//    history). The history is zero-extended to IDX_W bits; a PC narrower
//    than IDX_W is zero-extended as well.
//
// Ports:
//    clk             in   clock
//    reset           in   async active-high reset
//    pred_valid      in   1        predict request this cycle
//    pred_pc         in   [PC_W]   PC of the branch being predicted
//    resp_valid      out  1        response valid (one cycle after request)
//    resp_taken      out  1        predicted direction
//    resp_idx        out  [IDX_W]  table index used
//    resp_ghr        out  [GHR_W]  GHR before the speculative shift
//    upd_valid       in   1        branch resolved this cycle
//    upd_idx         in   [IDX_W]  index carried from resp_idx
//    upd_ghr         in   [GHR_W]  checkpoint carried from resp_ghr
//    upd_taken       in   1        actual outcome
//    upd_mispredict  in   1        resolved direction differs from prediction
//    ghr_out         out  [GHR_W]  current speculative GHR
//    mispredict_cnt  out  [CNT_W]  saturating mispredict count
// -----------------------------------------------------------------------------
module gshare_predictor
   import gpred_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int GHR_W = 4,
   parameter int IDX_W = 4,
   parameter int CTR_W = 2,
   parameter int MODE  = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pred_valid,
   input  logic [PC_W-1:0]  pred_pc,
   output logic             resp_valid,
   output logic             resp_taken,
   output logic [IDX_W-1:0] resp_idx,
   output logic [GHR_W-1:0] resp_ghr,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic [GHR_W-1:0] upd_ghr,
   input  logic             upd_taken,
   input  logic             upd_mispredict,
   output logic [GHR_W-1:0] ghr_out,
   output logic [CNT_W-1:0] mispredict_cnt
);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [GHR_W-1:0] ghr_q,          ghr_d;
   logic             resp_valid_q;
   logic             resp_taken_q;
   logic [IDX_W-1:0] resp_idx_q;
   logic [GHR_W-1:0] resp_ghr_q;
   logic [CNT_W-1:0] mis_cnt_q,      mis_cnt_d;

   // ---------------------------------------------------------------------
   // Index hash
   // ---------------------------------------------------------------------
   logic [IDX_W-1:0] pc_idx;
   logic [IDX_W-1:0] ghr_ext;
   logic [IDX_W-1:0] hash_idx;

   generate
      if (PC_W >= IDX_W) begin : g_pc_trunc
         assign pc_idx = pred_pc[IDX_W-1:0];
      end else begin : g_pc_zext
         assign pc_idx = {{(IDX_W - PC_W){1'b0}}, pred_pc};
      end

      if (GHR_W == IDX_W) begin : g_ghr_full
         assign ghr_ext = ghr_q;
      end else begin : g_ghr_zext
         assign ghr_ext = {{(IDX_W - GHR_W){1'b0}}, ghr_q};
      end

      if (MODE == int'(GPRED_MODE_GSHARE)) begin : g_gshare
         assign hash_idx = pc_idx ^ ghr_ext;
      end else begin : g_gag
         assign hash_idx = ghr_ext;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Counter table
   // ---------------------------------------------------------------------
   logic [CTR_W-1:0] rd_ctr;
   logic             pred_taken;

   gpred_ctr_table #(
      .IDX_W (IDX_W),
      .CTR_W (CTR_W)
   ) u_table (
      .clk        (clk),
      .reset      (reset),
      .rd_idx_i   (hash_idx),
      .rd_ctr_o   (rd_ctr),
      .wr_en_i    (upd_valid),
      .wr_idx_i   (upd_idx),
      .wr_taken_i (upd_taken)
   );

   assign pred_taken = rd_ctr[CTR_W-1];

   // ---------------------------------------------------------------------
   // History: speculative shift and checkpoint repair
   // ---------------------------------------------------------------------
   logic [GHR_W-1:0] spec_ghr;
   logic [GHR_W-1:0] repair_ghr;
   logic             repair;

   generate
      if (GHR_W == 1) begin : g_ghr_one
         assign spec_ghr   = pred_taken;
         assign repair_ghr = upd_taken;
      end else begin : g_ghr_shift
         assign spec_ghr   = {ghr_q[GHR_W-2:0], pred_taken};
         assign repair_ghr = {upd_ghr[GHR_W-2:0], upd_taken};
      end
   endgenerate

   assign repair = upd_valid && upd_mispredict;

   // A repair overrides the same-cycle speculative shift: the branch being
   // predicted now is on the wrong path and its history bit must not survive.
   always_comb begin
      ghr_d = ghr_q;
      if (repair) begin
         ghr_d = repair_ghr;
      end else if (pred_valid) begin
         ghr_d = spec_ghr;
      end
   end

   always_comb begin
      mis_cnt_d = mis_cnt_q;
      if (repair && (mis_cnt_q != '1)) begin
         mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_q        <= '0;
         mis_cnt_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_taken_q <= 1'b0;
         resp_idx_q   <= '0;
         resp_ghr_q   <= '0;
      end else begin
         ghr_q        <= ghr_d;
         mis_cnt_q    <= mis_cnt_d;
         resp_valid_q <= pred_valid;
         // Response payload holds while no request is accepted.
         if (pred_valid) begin
            resp_taken_q <= pred_taken;
            resp_idx_q   <= hash_idx;
            resp_ghr_q   <= ghr_q;
         end
      end
   end

   assign resp_valid     = resp_valid_q;
   assign resp_taken     = resp_taken_q;
   assign resp_idx       = resp_idx_q;
   assign resp_ghr       = resp_ghr_q;
   assign ghr_out        = ghr_q;
   assign mispredict_cnt = mis_cnt_q;

   // Bits that legitimately go unused in some configurations: upper PC
   // bits, the whole PC in GAg mode, the oldest checkpoint bit (shifted
   // out on repair) and the counter bits below the direction MSB.
   logic unused_ok;
   assign unused_ok = ^{pred_pc, pc_idx, upd_ghr, rd_ctr};

endmodule : gshare_predictor

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Parametrised global branch predictor; successor to the fixed 4-bit-history GAg predictor.
- Configurable history length, table depth and counter width. Selectable GAg or gshare (PC XOR history) indexing.
- Speculative global history register (GHR), with repair from a checkpoint on mispredict.
- Registered prediction response and a decoupled resolve/update port. Sits between fetch (predict) and execute (resolve).

Parameters:
- PC_W, 8, branch PC width.
- GHR_W, 4, global history length; must satisfy GHR_W <= IDX_W.
- IDX_W, 4, table index width; table depth = 2**IDX_W.
- CTR_W, 2, saturating counter width; must be >= 1.
- MODE, 1, index mode: 0 = GAg (history only), 1 = gshare (XOR).
- CNT_W, 16, mispredict statistics counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, async active-high reset.
- pred_valid, in, 1, predict request this cycle.
- pred_pc, in, PC_W, PC of the branch being predicted.
- resp_valid, out, 1, prediction response valid (1 cycle after pred_valid).
- resp_taken, out, 1, predicted direction.
- resp_idx, out, IDX_W, table index used; carried with the branch down the pipe.
- resp_ghr, out, GHR_W, GHR value before speculative shift (checkpoint).
- upd_valid, in, 1, branch resolved this cycle.
- upd_idx, in, IDX_W, index from resp_idx.
- upd_ghr, in, GHR_W, checkpoint from resp_ghr.
- upd_taken, in, 1, actual outcome.
- upd_mispredict, in, 1, resolved direction differs from prediction.
- ghr_out, out, GHR_W, current speculative GHR (debug).
- mispredict_cnt, out, CNT_W, saturating count of mispredicts.

Behaviour:
- Reset (async, active-high):
  - GHR = 0.
  - All counters = 2**(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
  - resp_valid = 0, resp_taken = 0, resp_idx = 0, resp_ghr = 0, mispredict_cnt = 0.
  - Asserting reset mid-operation discards in-flight responses.
- Index:
  - MODE 0: idx = zero-extended GHR.
  - MODE 1: idx = pred_pc[IDX_W-1:0] XOR zero-extended GHR. If PC_W < IDX_W, the PC is zero-extended first.
- Predict (latency 1): when pred_valid=1 at edge N, at edge N+1:
  - resp_valid=1.
  - resp_taken = MSB of table[idx], using the table value before any same-cycle update (read-before-write).
  - resp_idx = idx.
  - resp_ghr = GHR before the shift.
  - When pred_valid=0, resp_valid deasserts next edge; other resp_* fields hold.
- Speculative history: on an accepted predict, GHR <= {GHR[GHR_W-2:0], predicted_taken}. For GHR_W=1, GHR <= predicted_taken.
- Update: when upd_valid=1, table[upd_idx] saturates toward the outcome:
  - +1 if taken, capped at all-ones.
  - -1 if not taken, floored at 0.
  - Resolution is never stalled and has no backpressure.
- Repair: when upd_valid and upd_mispredict:
  - GHR <= {upd_ghr[GHR_W-2:0], upd_taken}.
  - mispredict_cnt increments and saturates at all-ones.
  - upd_mispredict is ignored when upd_valid=0.
- Simultaneous predict and repair in the same cycle:
  - Repair wins the GHR write.
  - The prediction still responds normally, using the pre-repair GHR for its index.
  - The speculative shift is dropped.
- Simultaneous predict and update to the same index: the prediction sees the old counter value; the update is committed.
- Updates with no mispredict leave the GHR untouched.

Decomposition:
- Shared package gpred_pkg:
  - Counter init/saturation helper constants.
  - MODE encodings GPRED_MODE_GAG=0 and GPRED_MODE_GSHARE=1.
- Sub-module gpred_ctr_table (IDX_W, CTR_W):
  - One read port, one write port, read-before-write.
  - Saturating update logic internal to the table.
  - Async reset initialisation of all entries.
- Top level owns the GHR, index hash, response registers and stats counter.

Test Plan (defaults, MODE=1):
- Reset → resp_valid=0, ghr_out=0, mispredict_cnt=0. Predict pc=0x05 → next cycle resp_taken=0, resp_idx=5, resp_ghr=0, ghr_out=0.
- Three updates idx=5 taken, no mispredict → counter 01→10→11→11 (saturated). Predict pc=0x05 with GHR=0 → resp_taken=1, ghr_out=0001.
- GHR=0011, predict pc=0x0C → resp_idx=0xF. MODE=0 build, same stimulus → resp_idx=0x3.
- Mispredict repair: upd_valid=1, upd_mispredict=1, upd_ghr=0110, upd_taken=1 → ghr_out=1101, mispredict_cnt=1. The same cycle's pred_valid still responds, and its speculative shift is dropped.
- Same-index collision: counter idx=2 at 01, predict idx=2 and update idx=2 taken in the same cycle → resp_taken=0. The next predict of idx=2 → resp_taken=1.
- Assert reset while resp_valid=1 and counters trained → all outputs return to reset values immediately, without waiting for a clock edge. Counters return to 01.
